// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a show-ahead receive FIFO.
//
// The serial input is synchronised through two flops. A counter-driven FSM
// samples it in the middle of each bit and assembles bytes LSB first.
// Completed bytes go into a small FIFO. Two sticky error flags report a bad
// stop bit and a byte that was dropped because the FIFO was full.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   rxd        serial line (asynchronous to clk, idle high)
//   rx_data    FIFO head byte, meaningful only while rx_valid=1
//   rx_valid   FIFO not empty
//   rx_ready   consumer pops the head when rx_valid && rx_ready at a clk edge
//   clr_err    single-cycle pulse that clears frame_err and overrun
//   frame_err  sticky: a stop bit was sampled low
//   overrun    sticky: a completed byte was dropped (FIFO full)
//   rx_busy    receiver FSM is not idle
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 27000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       clr_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam int unsigned PW           = AW + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    // ------------------------------------------------------------------
    // Input synchroniser (resets to the idle line level)
    // ------------------------------------------------------------------
    logic rxd_meta_q;
    logic rxd_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s      <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s      <= rxd_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM: state register
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM: next state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rxd_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A start bit that is no longer low at mid-bit was a glitch
                    state_d   = rxd_s ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxd_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    // Returning to idle mid stop bit lets the next start edge resync
                    state_d = rxd_s ? StIdle : StWaitHigh;
                end
            end
            StWaitHigh: begin
                cnt_d = '0;
                if (rxd_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver FSM: outputs
    // ------------------------------------------------------------------
    logic stop_tick;
    logic push;
    logic frame_set;

    always_comb begin
        rx_busy   = (state_q != StIdle);
        stop_tick = (state_q == StStop) && (cnt_q == BIT_LAST);
        push      = stop_tick && rxd_s;
        frame_set = stop_tick && !rxd_s;
    end

    // ------------------------------------------------------------------
    // Show-ahead receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic          empty;
    logic          full;
    logic          pop;
    logic          accept;
    logic          drop;

    always_comb begin
        empty  = (wr_ptr_q == rd_ptr_q);
        // Full when the pointers differ only in the wrap bit
        full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop    = !empty && rx_ready;
        // A pop in the same cycle frees the slot the push writes into
        accept = push && (!full || pop);
        drop   = push && full && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
                wr_ptr_q                <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    assign rx_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign rx_valid = !empty;

    // ------------------------------------------------------------------
    // Sticky error flags: a set in the same cycle wins over clr_err
    // ------------------------------------------------------------------
    logic frame_err_q;
    logic overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_set || (frame_err_q && !clr_err);
            overrun_q   <= drop || (overrun_q && !clr_err);
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit, 4-entry FIFO.
// Stimulus pushes expected bytes into exp_q; a monitor pops and compares on
// every rx_valid && rx_ready handshake.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       clr_err;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];

    uart_rx #(
        .CLK_FREQ  (16),
        .BAUD_RATE (1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .clr_err  (clr_err),
        .frame_err(frame_err),
        .overrun  (overrun),
        .rx_busy  (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] fr(input logic [7:0] b, input logic stop);
        return {stop, b, 1'b0};
    endfunction

    // Drives the first n bits of a frame, 16 clocks each; caller is at posedge+1.
    task automatic send_bits(input logic [9:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            rxd = f[i];
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bits(fr(b, stop), 10);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every handshake against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rx_valid && rx_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected: got %02h expected none", rx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        bad++;
                        $display("FAIL pop_data: got %02h expected %02h", rx_data, e);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst      = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        clr_err  = 1'b0;
        #1;
        chk("reset_valid", 32'(rx_valid), 0);
        chk("reset_data", 32'(rx_data), 0);
        chk("reset_busy", 32'(rx_busy), 0);
        chk("reset_ferr", 32'(frame_err), 0);
        chk("reset_ovr", 32'(overrun), 0);
        cycles(3);
        rst = 1'b0;
        cycles(4);

        // 1: single frame, latency from the falling edge
        exp_q.push_back(8'h55);
        n = 0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                while (!rx_valid && n < 300) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        join
        chk("t1_latency_ok", 32'(n >= 153 && n <= 155), 1);
        chk("t1_valid", 32'(rx_valid), 1);
        chk("t1_data", 32'(rx_data), 32'h55);
        chk("t1_ferr", 32'(frame_err), 0);
        chk("t1_ovr", 32'(overrun), 0);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        chk("t1_drained", 32'(rx_valid), 0);

        // 2: start-bit glitch is rejected
        rxd = 1'b0;
        cycles(4);
        chk("t2_busy_on", 32'(rx_busy), 1);
        rxd = 1'b1;
        n = 0;
        while (rx_busy && n < 12) begin
            cycles(1);
            n++;
        end
        chk("t2_busy_off", 32'(rx_busy), 0);
        cycles(10);
        chk("t2_valid", 32'(rx_valid), 0);
        chk("t2_ferr", 32'(frame_err), 0);

        // 3: bad stop bit, held break, then a clean frame
        send_frame(8'hA3, 1'b0);
        chk("t3_ferr_set", 32'(frame_err), 1);
        cycles(64);
        chk("t3_busy_break", 32'(rx_busy), 1);
        rxd = 1'b1;
        cycles(20);
        chk("t3_idle", 32'(rx_busy), 0);
        chk("t3_no_byte", 32'(rx_valid), 0);
        exp_q.push_back(8'h3C);
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b1);
        cycles(3);
        rx_ready = 1'b0;
        chk("t3_after_3c", 32'(rx_valid), 0);
        chk("t3_ferr_still", 32'(frame_err), 1);
        clr_err = 1'b1;
        cycles(1);
        clr_err = 1'b0;
        chk("t3_ferr_clr", 32'(frame_err), 0);

        // 4: overrun on the fifth byte
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
            if (i == 4) chk("t4_no_ovr_full", 32'(overrun), 0);
        end
        chk("t4_ovr", 32'(overrun), 1);
        rx_ready = 1'b1;
        cycles(6);
        rx_ready = 1'b0;
        chk("t4_drained", 32'(rx_valid), 0);
        clr_err = 1'b1;
        cycles(1);
        clr_err = 1'b0;
        chk("t4_ovr_clr", 32'(overrun), 0);

        // 5: pop on the push cycle of a full FIFO keeps the byte
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h11 + 8'(i));
            send_frame(8'h11 + 8'(i), 1'b1);
        end
        exp_q.push_back(8'h77);
        fork
            send_frame(8'h77, 1'b1);
            begin
                cycles(154);
                rx_ready = 1'b1;
                cycles(1);
                rx_ready = 1'b0;
            end
        join
        chk("t5_ovr", 32'(overrun), 0);
        chk("t5_valid", 32'(rx_valid), 1);
        rx_ready = 1'b1;
        cycles(4);
        rx_ready = 1'b0;
        chk("t5_count4", 32'(rx_valid), 0);

        // 6: reset mid-frame clears everything at once
        send_frame(8'h5A, 1'b1);
        chk("t6_pre_valid", 32'(rx_valid), 1);
        send_bits(fr(8'h9A, 1'b1), 4);
        rxd = 1'b1;
        cycles(8);
        chk("t6_pre_busy", 32'(rx_busy), 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(rx_valid), 0);
        chk("t6_rst_data", 32'(rx_data), 0);
        chk("t6_rst_busy", 32'(rx_busy), 0);
        chk("t6_rst_ferr", 32'(frame_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(20);
        exp_q.push_back(8'hC3);
        rx_ready = 1'b1;
        send_frame(8'hC3, 1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            cycles(1);
            n++;
        end
        rx_ready = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 0);
        chk("final_ferr", 32'(frame_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
